// File: rtl/syscall_pkg.sv
// Shared syscall codes, FSM state encoding and console ASCII constants.
package syscall_pkg;

  localparam logic [31:0] CODE_PRINT_INT  = 32'd1;
  localparam logic [31:0] CODE_EXIT       = 32'd10;
  localparam logic [31:0] CODE_PRINT_CHAR = 32'd11;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_SIGN   = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  // Decimal digit to its ASCII character.
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return ASCII_ZERO + 8'(d);
  endfunction

endpackage

// File: rtl/div10_step.sv
// One combinational divide-by-10 step: quotient and remainder of a 32-bit value.
module div10_step (
  input  logic [31:0] value,
  output logic [31:0] quotient,
  output logic [3:0]  remainder
);

  // Quotient and decimal remainder of the current magnitude.
  always_comb begin
    quotient  = value / 32'd10;
    remainder = 4'(value % 32'd10);
  end

endmodule

// File: rtl/syscall_responder.sv
// Services print-int, print-char and exit syscalls; streams ASCII bytes to a console sink.
module syscall_responder
  import syscall_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sys_req,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        halt,
  output logic [31:0] exit_code,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        err_unknown
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  state_t        state;
  logic [31:0]   mag;
  logic          neg;
  logic [CW-1:0] cnt;
  logic [3:0]    stack [MAX_DIGITS];

  logic [31:0]   quot;
  logic [3:0]    rem;
  logic [3:0]    top_digit;
  logic          push;
  logic          req_known;

  div10_step u_div10 (
    .value     (mag),
    .quotient  (quot),
    .remainder (rem)
  );

  // Stack top and request decode; the final non-negative digit bypasses the stack.
  always_comb begin
    top_digit = stack[IW'(cnt - CW'(1))];
    push      = (state == ST_CONV) && ((quot != 32'd0) || neg);
    req_known = (v0 == CODE_PRINT_INT) || (v0 == CODE_EXIT) || (v0 == CODE_PRINT_CHAR);
  end

  // Stall is combinational so the processor freezes in the request cycle itself.
  always_comb begin
    stall = 1'b0;
    case (state)
      ST_CONV, ST_SIGN, ST_EMIT, ST_HALTED: stall = 1'b1;
      ST_IDLE:                              stall = sys_req && req_known;
      default:                              stall = 1'b0;
    endcase
  end

  // Digit stack storage; validity is tracked solely by cnt.
  always_ff @(posedge clock) begin
    if (push && (cnt < CW'(MAX_DIGITS))) begin
      stack[IW'(cnt)] <= rem;
    end
  end

  // Syscall FSM with registered console, halt and error outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mag         <= 32'd0;
      neg         <= 1'b0;
      cnt         <= '0;
      halt        <= 1'b0;
      exit_code   <= 32'd0;
      out_valid   <= 1'b0;
      out_data    <= 8'd0;
      err_unknown <= 1'b0;
    end else begin
      err_unknown <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sys_req) begin
            if (v0 == CODE_PRINT_INT) begin
              mag   <= a0[31] ? (~a0 + 32'd1) : a0;
              neg   <= a0[31];
              cnt   <= '0;
              state <= ST_CONV;
            end else if (v0 == CODE_PRINT_CHAR) begin
              cnt       <= '0;
              out_valid <= 1'b1;
              out_data  <= a0[7:0];
              state     <= ST_EMIT;
            end else if (v0 == CODE_EXIT) begin
              exit_code <= a0;
              halt      <= 1'b1;
              state     <= ST_HALTED;
            end else begin
              err_unknown <= 1'b1;
            end
          end
        end
        ST_CONV: begin
          mag <= quot;
          if (push) begin
            cnt <= cnt + CW'(1);
          end
          if (quot == 32'd0) begin
            out_valid <= 1'b1;
            out_data  <= neg ? ASCII_MINUS : digit_ascii(rem);
            state     <= neg ? ST_SIGN : ST_EMIT;
          end
        end
        ST_SIGN: begin
          if (out_ready) begin
            out_data <= digit_ascii(top_digit);
            cnt      <= cnt - CW'(1);
            state    <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (cnt == '0) begin
              out_valid <= 1'b0;
              state     <= ST_DONE;
            end else begin
              out_data <= digit_ascii(top_digit);
              cnt      <= cnt - CW'(1);
            end
          end
        end
        ST_DONE:   state <= ST_IDLE;
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_responder.sv
// Directed bench for syscall_responder with a byte scoreboard fed by the stimulus.
module tb_syscall_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        sys_req;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        stall;
  logic        halt;
  logic [31:0] exit_code;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        err_unknown;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  syscall_responder #(.MAX_DIGITS(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .sys_req     (sys_req),
    .v0          (v0),
    .a0          (a0),
    .stall       (stall),
    .halt        (halt),
    .exit_code   (exit_code),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .err_unknown (err_unknown)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a byte transfers at the next rising edge when valid and ready are both high.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL byte_unexpected actual=%h required=none", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL byte actual=%h required=%h", out_data, e);
        end
      end
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Present one request for a single cycle; returns at the request-cycle negedge.
  task automatic issue(input logic [31:0] code, input logic [31:0] arg);
    @(posedge clock); #1;
    sys_req = 1'b1; v0 = code; a0 = arg;
    @(negedge clock);
  endtask

  // Wait for stall to drop (DONE); n counts stall-high negedges including the request cycle.
  task automatic wait_done(output int n);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      sys_req = 1'b0; v0 = 32'd1; a0 = 32'h5A5A_5A5A;
      @(negedge clock);
      if (!stall) break;
      n++;
    end
    check("reached_done", 32'(stall), 32'd0);
  endtask

  task automatic run_print_int(input logic [31:0] arg, input string s, input string tag);
    int n;
    push_str(s);
    issue(32'd1, arg);
    check({tag, "_req_stall"}, 32'(stall), 32'd1);
    wait_done(n);
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; sys_req = 1'b0; v0 = 32'd0; a0 = 32'd0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_exit_code", exit_code, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_err", 32'(err_unknown), 32'd0);
    @(posedge clock); #1; reset = 1'b0;

    // 1234: request + 4 conversion + 4 emit cycles of stall, then one DONE cycle low
    push_str("1234");
    issue(32'd1, 32'd1234);
    check("p1234_req_stall", 32'(stall), 32'd1);
    wait_done(n);
    check("p1234_stall_cycles", 32'(n), 32'd9);
    check("p1234_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1; sys_req = 1'b1; v0 = 32'd5;
    @(negedge clock);
    check("p1234_idle_after_done", 32'(stall), 32'd0);
    @(posedge clock); #1; sys_req = 1'b0;

    run_print_int(-32'sd7, "-7", "pm7");
    run_print_int(32'd0, "0", "p0");
    run_print_int(32'h8000_0000, "-2147483648", "pmin");

    // print-char with the sink stalled for three cycles
    out_ready = 1'b0;
    exp_q.push_back(8'h41);
    issue(32'd11, 32'hFFFF_FF41);
    check("chr_req_stall", 32'(stall), 32'd1);
    @(posedge clock); #1; sys_req = 1'b0; a0 = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("chr_hold_valid", 32'(out_valid), 32'd1);
      check("chr_hold_data", 32'(out_data), 32'h41);
      check("chr_hold_stall", 32'(stall), 32'd1);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(negedge clock);
    wait_done(n);
    check("chr_queue_empty", 32'(exp_q.size()), 32'd0);

    // unknown code: registered one-cycle error pulse, no stall, no bytes
    issue(32'd5, 32'd99);
    check("unk_stall", 32'(stall), 32'd0);
    @(posedge clock); #1; sys_req = 1'b0;
    @(negedge clock);
    check("unk_pulse", 32'(err_unknown), 32'd1);
    check("unk_no_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    check("unk_pulse_end", 32'(err_unknown), 32'd0);

    // reset in the middle of emitting 1234
    push_str("1234");
    issue(32'd1, 32'd1234);
    @(posedge clock); #1; sys_req = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() > 2; i++) @(negedge clock);
    check("mid_two_sent", 32'(exp_q.size()), 32'd2);
    @(posedge clock); #1; reset = 1'b1; #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    exp_q.delete();
    @(posedge clock); #1; reset = 1'b0;
    run_print_int(32'd1234, "1234", "fresh");

    // exit with a0 = -1, then later requests are ignored
    issue(32'd10, 32'hFFFF_FFFF);
    check("exit_req_stall", 32'(stall), 32'd1);
    @(posedge clock); #1; sys_req = 1'b0;
    @(negedge clock);
    check("exit_halt", 32'(halt), 32'd1);
    check("exit_code", exit_code, 32'hFFFF_FFFF);
    check("exit_stall", 32'(stall), 32'd1);
    issue(32'd11, 32'd65);
    @(posedge clock); #1; sys_req = 1'b0;
    repeat (4) @(negedge clock);
    check("halted_halt", 32'(halt), 32'd1);
    check("halted_stall", 32'(stall), 32'd1);
    check("halted_valid", 32'(out_valid), 32'd0);
    check("halted_code", exit_code, 32'hFFFF_FFFF);
    @(posedge clock); #1; reset = 1'b1;
    @(negedge clock);
    check("post_rst_halt", 32'(halt), 32'd0);
    check("post_rst_stall", 32'(stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
